// File: rtl/nw_traceback_ctrl_if.sv
// Write port of the aligned-sequence RAMs (A and B share one strobe and index).
// The traceback controller drives it as master and the RAM side is the slave.
interface nw_traceback_ctrl_if #(
  parameter int N = 128
) ();
  localparam int BitAddr = $clog2(N);

  logic               en_traceB;
  logic [BitAddr:0]   k;
  logic [2:0]         al_a;
  logic [2:0]         al_b;

  modport master (output en_traceB, k, al_a, al_b);
  modport slave  (input  en_traceB, k, al_a, al_b);
endinterface

// File: rtl/nw_traceback_ctrl.sv
// Needleman-Wunsch traceback: walks the direction matrix from (len_a,len_b) to (0,0)
// and writes one aligned symbol pair per step, last alignment column first.
module nw_traceback_ctrl #(
  parameter  int N       = 128,
  localparam int BitAddr = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BitAddr:0]     len_a,
  input  logic [BitAddr:0]     len_b,
  output logic [BitAddr:0]     dir_i,
  output logic [BitAddr:0]     dir_j,
  input  logic [1:0]           dir_data,
  output logic [BitAddr:0]     seq_a_addr,
  output logic [BitAddr:0]     seq_b_addr,
  input  logic [2:0]           seq_a_data,
  input  logic [2:0]           seq_b_data,
  nw_traceback_ctrl_if.master  wr,
  output logic [BitAddr+1:0]   al_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int         IW  = BitAddr + 1;
  localparam logic [2:0] Gap = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_e;
  typedef enum logic [1:0] {D_DIAG = 2'b00, D_UP = 2'b01, D_LEFT = 2'b10, D_INV = 2'b11} dir_e;

  state_e        state_q;
  dir_e          dir_q;
  logic [IW-1:0] i_q, j_q;
  logic [IW:0]   cnt_q;
  logic          en_q;
  logic [2:0]    al_a_q, al_b_q;
  logic [IW-1:0] dir_i_q, dir_j_q, seq_a_addr_q, seq_b_addr_q;
  logic [IW:0]   al_len_q;
  logic          busy_q, done_q, err_q;

  dir_e          step_dir;
  logic [IW-1:0] i_d, j_d;

  // Boundary rows/columns override the stored direction; i==0 wins over j==0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    step_dir = dir_e'(dir_data);
    if (i_q == '0)      step_dir = D_LEFT;
    else if (j_q == '0) step_dir = D_UP;

    i_d = i_q;
    j_d = j_q;
    case (dir_q)
      D_DIAG: begin
        i_d = i_q - 1'b1;
        j_d = j_q - 1'b1;
      end
      D_UP:    i_d = i_q - 1'b1;
      D_LEFT:  j_d = j_q - 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dir_q        <= D_DIAG;
      i_q          <= '0;
      j_q          <= '0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      al_a_q       <= '0;
      al_b_q       <= '0;
      dir_i_q      <= '0;
      dir_j_q      <= '0;
      seq_a_addr_q <= '0;
      seq_b_addr_q <= '0;
      al_len_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            i_q   <= len_a;
            j_q   <= len_b;
            cnt_q <= '0;
            err_q <= 1'b0;
            if (len_a == '0 && len_b == '0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              al_len_q <= '0;
            end else begin
              state_q      <= S_ISSUE;
              busy_q       <= 1'b1;
              dir_i_q      <= len_a;
              dir_j_q      <= len_b;
              seq_a_addr_q <= len_a - 1'b1;
              seq_b_addr_q <= len_b - 1'b1;
            end
          end
        end

        S_ISSUE: state_q <= S_WAIT;

        // Read data is valid now and stays valid while the addresses are held,
        // so the pair is captured here and presented with the strobe in EMIT.
        S_WAIT: begin
          dir_q   <= step_dir;
          en_q    <= (step_dir != D_INV);
          state_q <= S_EMIT;
          case (step_dir)
            D_DIAG: begin
              al_a_q <= seq_a_data;
              al_b_q <= seq_b_data;
            end
            D_UP: begin
              al_a_q <= seq_a_data;
              al_b_q <= Gap;
            end
            D_LEFT: begin
              al_a_q <= Gap;
              al_b_q <= seq_b_data;
            end
            default: ;
          endcase
        end

        S_EMIT: begin
          en_q <= 1'b0;
          if (dir_q == D_INV) begin
            err_q    <= 1'b1;
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            al_len_q <= cnt_q;
          end else begin
            i_q   <= i_d;
            j_q   <= j_d;
            cnt_q <= cnt_q + 1'b1;
            if (i_d == '0 && j_d == '0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              al_len_q <= cnt_q + 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              dir_i_q      <= i_d;
              dir_j_q      <= j_d;
              seq_a_addr_q <= i_d - 1'b1;
              seq_b_addr_q <= j_d - 1'b1;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dir_i        = dir_i_q;
  assign dir_j        = dir_j_q;
  assign seq_a_addr   = seq_a_addr_q;
  assign seq_b_addr   = seq_b_addr_q;
  assign wr.en_traceB = en_q;
  assign wr.k         = cnt_q[IW-1:0];
  assign wr.al_a      = al_a_q;
  assign wr.al_b      = al_b_q;
  assign al_len       = al_len_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_nw_traceback_ctrl.sv
// Scoreboard bench for nw_traceback_ctrl (N=4): directed runs push expected writes and
// completions into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_nw_traceback_ctrl;

  localparam int N  = 4;
  localparam int IW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] len_a, len_b;
  logic [IW-1:0] dir_i, dir_j, seq_a_addr, seq_b_addr;
  logic [1:0]    dir_data;
  logic [2:0]    seq_a_data, seq_b_data;
  logic [IW:0]   al_len;
  logic          busy, done, err;

  nw_traceback_ctrl_if #(.N(N)) wr_if ();

  nw_traceback_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len_a      (len_a),
    .len_b      (len_b),
    .dir_i      (dir_i),
    .dir_j      (dir_j),
    .dir_data   (dir_data),
    .seq_a_addr (seq_a_addr),
    .seq_b_addr (seq_b_addr),
    .seq_a_data (seq_a_data),
    .seq_b_data (seq_b_data),
    .wr         (wr_if.master),
    .al_len     (al_len),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-address RAM models: data appears one cycle after the address.
  logic [1:0] dir_mem [0:7][0:7];
  logic [2:0] a_mem [0:7];
  logic [2:0] b_mem [0:7];
  always @(posedge clk) begin
    dir_data   <= dir_mem[dir_i][dir_j];
    seq_a_data <= a_mem[seq_a_addr];
    seq_b_data <= b_mem[seq_b_addr];
  end

  typedef struct { logic [2:0] k; logic [2:0] a; logic [2:0] b; } wr_t;
  typedef struct { logic [3:0] len; logic err; int cyc; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];
  wr_t   e_wr;
  done_t e_done;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int k, input int a, input int b);
    wr_q.push_back('{k: 3'(k), a: 3'(a), b: 3'(b)});
  endtask

  task automatic fill_dir(input logic [1:0] v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) dir_mem[i][j] = v;
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_if.en_traceB) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got k=%0d a=%0d b=%0d expected no write", wr_if.k, wr_if.al_a, wr_if.al_b);
      end else begin
        e_wr = wr_q.pop_front();
        check("wr_k", 32'(wr_if.k), 32'(e_wr.k));
        check("wr_al_a", 32'(wr_if.al_a), 32'(e_wr.a));
        check("wr_al_b", 32'(wr_if.al_b), 32'(e_wr.b));
      end
    end
    if (rst_n && done) begin
      if (done_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e_done = done_q.pop_front();
        check("done_al_len", 32'(al_len), 32'(e_done.len));
        check("done_err", 32'(err), 32'(e_done.err));
        check("done_cycle", 32'(cyc), 32'(e_done.cyc));
        check("done_busy_low", 32'(busy), 32'd0);
      end
    end
  end

  // poke=1 raises start while busy (WAIT of step 1); poke=2 raises it during the DONE cycle.
  task automatic run(input int la, input int lb, input int steps, input int exp_len,
                     input int exp_err, input int poke);
    int  t;
    bit  seen;
    @(negedge clk);
    len_a = IW'(la);
    len_b = IW'(lb);
    start = 1'b1;
    t     = cyc;
    done_q.push_back('{len: 4'(exp_len), err: exp_err[0], cyc: (steps == 0) ? t + 1 : t + 3 * steps + 1});
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      start = (poke == 1 && cyc == t + 2);
      if (n == 0) begin
        check("busy_after_start", 32'(busy), (steps != 0) ? 32'd1 : 32'd0);
        check("err_cleared_on_start", 32'(err), 32'd0);
      end
      if (done) begin
        seen = 1'b1;
        if (poke == 2) start = 1'b1;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
    @(negedge clk);
    start = 1'b0;
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    start = 1'b0;
    len_a = '0;
    len_b = '0;
    fill_dir(2'b00);
    for (int i = 0; i < 8; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en", 32'(wr_if.en_traceB), 32'd0);
    check("rst_k", 32'(wr_if.k), 32'd0);
    check("rst_al_a", 32'(wr_if.al_a), 32'd0);
    check("rst_al_b", 32'(wr_if.al_b), 32'd0);
    check("rst_al_len", 32'(al_len), 32'd0);
    check("rst_dir_i", 32'(dir_i), 32'd0);
    check("rst_dir_j", 32'(dir_j), 32'd0);
    check("rst_seq_a_addr", 32'(seq_a_addr), 32'd0);
    check("rst_seq_b_addr", 32'(seq_b_addr), 32'd0);

    // Identical sequences A=B=(1,2,3,5), all diag: pairs come out reversed.
    a_mem[0] = 3'd1; a_mem[1] = 3'd2; a_mem[2] = 3'd3; a_mem[3] = 3'd5;
    b_mem[0] = 3'd1; b_mem[1] = 3'd2; b_mem[2] = 3'd3; b_mem[3] = 3'd5;
    fill_dir(2'b00);
    push_wr(0, 5, 5); push_wr(1, 3, 3); push_wr(2, 2, 2); push_wr(3, 1, 1);
    run(4, 4, 4, 4, 0, 0);

    // Single indel, B=(6,7,0,3): diag (3,2), up (2,1), diag (1,1); start poked while busy.
    b_mem[0] = 3'd6; b_mem[1] = 3'd7; b_mem[2] = 3'd0; b_mem[3] = 3'd3;
    fill_dir(2'b11);
    dir_mem[3][2] = 2'b00; dir_mem[2][1] = 2'b01; dir_mem[1][1] = 2'b00;
    push_wr(0, 3, 7); push_wr(1, 2, 4); push_wr(2, 1, 6);
    run(3, 2, 3, 3, 0, 1);

    // len_a=0: forced left on every step, stored directions all invalid; start poked in DONE.
    fill_dir(2'b11);
    push_wr(0, 4, 0); push_wr(1, 4, 7); push_wr(2, 4, 6);
    run(0, 3, 3, 3, 0, 2);

    // Invalid direction at (2,2) after one diag from (3,3).
    fill_dir(2'b00);
    dir_mem[2][2] = 2'b11;
    push_wr(0, 3, 0);
    run(3, 3, 2, 1, 1, 0);
    check("err_sticky_in_idle", 32'(err), 32'd1);

    // Empty input.
    run(0, 0, 0, 0, 0, 0);

    // Reset during the second EMIT of a 4/4 run.
    b_mem[0] = 3'd1; b_mem[1] = 3'd2; b_mem[2] = 3'd3; b_mem[3] = 3'd5;
    fill_dir(2'b00);
    push_wr(0, 5, 5); push_wr(1, 3, 3);
    @(negedge clk);
    len_a = IW'(4);
    len_b = IW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40 && cnt < 2; n++) begin
      @(posedge clk);
      #2;
      if (wr_if.en_traceB) cnt++;
    end
    check("second_emit_reached", 32'(cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_en_drops", 32'(wr_if.en_traceB), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    wr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_al_len", 32'(al_len), 32'd0);
    push_wr(0, 5, 5); push_wr(1, 3, 3); push_wr(2, 2, 2); push_wr(3, 1, 1);
    run(4, 4, 4, 4, 0, 0);

    repeat (3) @(negedge clk);
    check("final_writes_left", 32'(wr_q.size()), 32'd0);
    check("final_dones_left", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
